alu_issue_stage: RTL and testbench

//  Issue stage directly upstream of the 32-bit ALU. Accepts decoded ALUOp/funct

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_ctrl_decode.sv | 33 +++
 rtl/alu_issue_stage.sv | 116 +++++++++++
 tb/tb_alu_issue_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, ALUOp/funct encodings and the decoded-op record
// shared by the issue stage, the ALU and their benches.
package alu_pkg;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_RSVD   = 2'b11
    } aluop_e;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NAND = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       cin;
        logic       bin;
        logic       illegal;
    } dec_t;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALUOp/funct to ALU control, carry-in,
// invert-B and illegal flag.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output dec_t       dec
);
    always_comb begin
        dec = '{ctrl: ALU_AND, cin: 1'b0, bin: 1'b0, illegal: 1'b0};
        case (aluop)
            ALUOP_MEM:    dec.ctrl = ALU_ADD;
            ALUOP_BRANCH: dec.ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec.ctrl = ALU_ADD;
                    FN_SUB:  dec.ctrl = ALU_SUB;
                    FN_AND:  dec.ctrl = ALU_AND;
                    FN_OR:   dec.ctrl = ALU_OR;
                    FN_NOR:  dec.ctrl = ALU_NOR;
                    FN_NAND: dec.ctrl = ALU_NAND;
                    FN_SLT:  dec.ctrl = ALU_SLT;
                    default: dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
        // subtraction and set-less-than both compute A + ~B + 1
        dec.cin = (dec.ctrl == ALU_SUB) || (dec.ctrl == ALU_SLT);
        dec.bin = dec.cin;
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes ALU ops and presents them through a registered
// output slot backed by one skid entry, with a saturating illegal-op counter.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_aluop,
    input  logic [5:0]       in_funct,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       ALU_control,
    output logic [WIDTH-1:0] src1,
    output logic [WIDTH-1:0] src2,
    output logic             cin,
    output logic             bin,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    dec_t             in_dec;
    logic             acc, load_out;
    logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    dec_t             out_dec_q, out_dec_d, skid_dec_q, skid_dec_d;
    logic [WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic [WIDTH-1:0] skid_a_q, skid_a_d, skid_b_q, skid_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    alu_ctrl_decode u_dec (.aluop(in_aluop), .funct(in_funct), .dec(in_dec));

    always_comb begin
        out_valid_d  = out_valid_q;
        out_dec_d    = out_dec_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        skid_valid_d = skid_valid_q;
        skid_dec_d   = skid_dec_q;
        skid_a_d     = skid_a_q;
        skid_b_d     = skid_b_q;
        cnt_d        = cnt_q;
        acc          = in_valid && in_ready_q;
        load_out     = !out_valid_q || out_ready;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            // in_ready is low whenever skid holds an op, so skid and input never compete
            if (load_out) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_dec_d    = skid_dec_q;
                    out_a_d      = skid_a_q;
                    out_b_d      = skid_b_q;
                    skid_valid_d = 1'b0;
                end else begin
                    out_valid_d = acc;
                    out_dec_d   = acc ? in_dec : out_dec_q;
                    out_a_d     = acc ? in_src1 : out_a_q;
                    out_b_d     = acc ? in_src2 : out_b_q;
                end
            end else if (acc) begin
                skid_valid_d = 1'b1;
                skid_dec_d   = in_dec;
                skid_a_d     = in_src1;
                skid_b_d     = in_src2;
            end
            if (acc && in_dec.illegal && cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + CNT_W'(1);
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_dec_q    <= '0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_dec_q   <= '0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
            in_ready_q   <= 1'b1;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_dec_q    <= out_dec_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            skid_valid_q <= skid_valid_d;
            skid_dec_q   <= skid_dec_d;
            skid_a_q     <= skid_a_d;
            skid_b_q     <= skid_b_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign ALU_control = out_dec_q.ctrl;
    assign cin         = out_dec_q.cin;
    assign bin         = out_dec_q.bin;
    assign illegal     = out_dec_q.illegal;
    assign src1        = out_a_q;
    assign src2        = out_b_q;
    assign illegal_cnt = cnt_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random stimulus against a queue-based
// reference of the issue stage (capacity two, in-order, flush/reset clear).
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [1:0]  in_aluop;
    logic [5:0]  in_funct;
    logic [31:0] in_src1, in_src2;
    logic        in_ready, out_valid, cin, bin, illegal;
    logic [3:0]  ALU_control;
    logic [31:0] src1, src2;
    logic [7:0]  illegal_cnt;
    logic        in_ready2, out_valid2, cin2, bin2, illegal2;
    logic [3:0]  ctrl2;
    logic [31:0] src1_2, src2_2;
    logic [1:0]  illegal_cnt2;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_funct(in_funct), .in_src1(in_src1), .in_src2(in_src2),
        .out_valid(out_valid), .out_ready(out_ready), .ALU_control(ALU_control),
        .src1(src1), .src2(src2), .cin(cin), .bin(bin), .illegal(illegal),
        .illegal_cnt(illegal_cnt)
    );

    alu_issue_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_aluop(in_aluop), .in_funct(in_funct), .in_src1(in_src1), .in_src2(in_src2),
        .out_valid(out_valid2), .out_ready(out_ready), .ALU_control(ctrl2),
        .src1(src1_2), .src2(src2_2), .cin(cin2), .bin(bin2), .illegal(illegal2),
        .illegal_cnt(illegal_cnt2)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic        cin, bin, ill;
        logic [31:0] a, b;
    } op_t;

    op_t q[$];
    int  cnt, cnt2, checks, failures;
    logic [5:0] legal_fn [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h26};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic op_t ref_op(input logic [1:0] op, input logic [5:0] fn,
                                   input logic [31:0] a, input logic [31:0] b);
        op_t o;
        o.a = a; o.b = b; o.ill = 1'b0; o.ctrl = 4'b0000;
        if (op == 2'b00) o.ctrl = 4'b0010;
        else if (op == 2'b01) o.ctrl = 4'b0110;
        else if (op == 2'b11) o.ill = 1'b1;
        else begin
            case (fn)
                6'h20: o.ctrl = 4'b0010;
                6'h22: o.ctrl = 4'b0110;
                6'h24: o.ctrl = 4'b0000;
                6'h25: o.ctrl = 4'b0001;
                6'h27: o.ctrl = 4'b1100;
                6'h2A: o.ctrl = 4'b0111;
                6'h26: o.ctrl = 4'b1101;
                default: o.ill = 1'b1;
            endcase
        end
        o.cin = (o.ctrl == 4'b0110) || (o.ctrl == 4'b0111);
        o.bin = o.cin;
        return o;
    endfunction

    task automatic compare();
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() != 0);
        chk("out_valid_w2", out_valid2, q.size() != 0);
        if (q.size() != 0) begin
            chk("ctrl", ALU_control, q[0].ctrl);
            chk("cin", cin, q[0].cin);
            chk("bin", bin, q[0].bin);
            chk("illegal", illegal, q[0].ill);
            chk("src1", src1, q[0].a);
            chk("src2", src2, q[0].b);
        end
        chk("illegal_cnt", illegal_cnt, cnt);
        chk("illegal_cnt_w2", illegal_cnt2, cnt2);
    endtask

    task automatic model_step();
        op_t o;
        bit  acc, drn;
        o   = ref_op(in_aluop, in_funct, in_src1, in_src2);
        acc = in_valid && q.size() < 2;
        drn = q.size() != 0 && out_ready;
        if (rst) begin
            q.delete(); cnt = 0; cnt2 = 0;
        end else if (flush) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                q.push_back(o);
                if (o.ill) begin
                    if (cnt < 255) cnt++;
                    if (cnt2 < 3) cnt2++;
                end
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic ordy, input logic fl, input logic r);
        in_valid = v; in_aluop = op; in_funct = fn; in_src1 = a; in_src2 = b;
        out_ready = ordy; flush = fl; rst = r;
        compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_ctrl"}, ALU_control, 4'b0000);
        chk({tag, "_src1"}, src1, 32'h0);
        chk({tag, "_src2"}, src2, 32'h0);
        chk({tag, "_cinbin"}, {cin, bin}, 2'b00);
        chk({tag, "_illegal"}, illegal, 1'b0);
        chk({tag, "_cnt"}, illegal_cnt, 8'h0);
        chk({tag, "_cnt_w2"}, illegal_cnt2, 2'h0);
    endtask

    initial begin
        int saved;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_aluop = 2'b00; in_funct = 6'h0; in_src1 = '0; in_src2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_checks("reset");

        cycle(1'b1, 2'b10, 6'h22, 32'd7, 32'd5, 1'b1, 1'b0, 1'b0);
        chk("sub_ctrl", ALU_control, 4'b0110);
        chk("sub_cinbin", {cin, bin}, 2'b11);
        chk("sub_src", {src1, src2}, {32'd7, 32'd5});
        chk("sub_illegal", illegal, 1'b0);
        idle();

        cycle(1'b1, 2'b00, 6'h0, 32'hA1, 32'hB1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 6'h0, 32'hA2, 32'hB2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'b10, 6'h24, 32'hA3, 32'hB3, 1'b0, 1'b0, 1'b0);
        chk("skid_full_in_ready", in_ready, 1'b0);
        chk("skid_full_head", src1, 32'hA1);
        repeat (2) cycle(1'b1, 2'b10, 6'h24, 32'hA3, 32'hB3, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 2'b10, 6'h25, 32'hA4, 32'hB4, 1'b1, 1'b0, 1'b0);
        chk("stream_tail", src1, 32'hA4);
        idle();

        cycle(1'b0, 2'b00, 6'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 2'b11, 6'h0, 32'h3, 32'h4, 1'b1, 1'b0, 1'b0);
        chk("ill_flag", illegal, 1'b1);
        chk("ill_ctrl", ALU_control, 4'b0000);
        chk("ill_cnt3", illegal_cnt, 8'd3);
        repeat (2) cycle(1'b1, 2'b11, 6'h0, 32'h3, 32'h4, 1'b1, 1'b0, 1'b0);
        idle();
        chk("ill_cnt5", illegal_cnt, 8'd5);
        chk("ill_sat_w2", illegal_cnt2, 2'd3);

        saved = cnt;
        cycle(1'b1, 2'b00, 6'h0, 32'h11, 32'h12, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 6'h0, 32'h13, 32'h14, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'b11, 6'h0, 32'h15, 32'h16, 1'b0, 1'b1, 1'b0);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_cnt", illegal_cnt, saved[7:0]);
        idle();

        cycle(1'b1, 2'b00, 6'h0, 32'h21, 32'h22, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 2'b10, 6'h2A, 32'h23, 32'h24, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'b10, 6'h3F, 32'h25, 32'h26, 1'b0, 1'b0, 1'b1);
        reset_checks("midrst");

        for (int i = 0; i < 9; i++) begin
            if (i < 7) cycle(1'b1, 2'b10, legal_fn[i], i, ~i, 1'b1, 1'b0, 1'b0);
            else cycle(1'b1, 2'(i - 7), 6'h0, i, ~i, 1'b1, 1'b0, 1'b0);
        end
        idle();

        for (int i = 0; i < 600; i++) begin
            logic [5:0] fn;
            fn = ($urandom_range(3) != 0) ? legal_fn[$urandom_range(6)] : 6'($urandom);
            cycle(1'($urandom_range(3) != 0), 2'($urandom), fn, $urandom, $urandom,
                  1'($urandom_range(9) < 6), 1'($urandom_range(39) == 0),
                  1'($urandom_range(149) == 0));
        end
        idle();
        compare();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
